// File: rtl/dtw_pkg.sv
// dtw_pkg: shared codes and defaults for the DTW host sequencer.
package dtw_pkg;
  localparam logic [1:0] SYS_IDLE      = 2'b00;
  localparam logic [1:0] SYS_LOAD_TEMP = 2'b01;
  localparam logic [1:0] SYS_LOAD_TEST = 2'b10;
  localparam logic [1:0] SYS_RUN       = 2'b11;
  localparam logic [3:0] DTW_DONE_STATE = 4'b1001;
  localparam int DEF_N_SAMPLES = 256;
  localparam int DEF_DATA_W    = 32;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD_TEMP, ST_LOAD_TEST, ST_RUN, ST_RESULT} state_t;
endpackage

// File: rtl/dtw_host_sequencer_watchdog.sv
// dtw_watchdog: saturating run-phase counter with clear; expired when all ones.
module dtw_watchdog #(
  parameter int W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  assign expired = &cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dtw_host_sequencer.sv
// dtw_host_sequencer: streams template/test samples into the DTW core, runs it and returns the distance.
module dtw_host_sequencer
  import dtw_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int ADDR_W = 8,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [3:0] DONE_STATE = DTW_DONE_STATE,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] core_data,
  output logic [ADDR_W-1:0] core_addr,
  output logic [1:0]        core_sys_status,
  output logic              core_en,
  input  logic [3:0]        core_state,
  input  logic [DATA_W-1:0] core_result
);
  if (ADDR_W < $clog2(N_SAMPLES)) begin : g_addr_check
    $error("ADDR_W too narrow for N_SAMPLES");
  end
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic hs, last_idx, len_err, in_run, wd_expired;
  assign hs = s_valid && s_ready;
  assign last_idx = idx == ADDR_W'(N_SAMPLES - 1);
  assign len_err = s_last != last_idx;
  assign in_run = state == ST_RUN;
  dtw_watchdog #(.W(TIMEOUT_W)) u_wd (
    .clk(clk), .rst_n(rst_n), .clr(!in_run), .en(in_run), .expired(wd_expired)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      busy <= 1'b0;
      s_ready <= 1'b0;
      m_data <= '0;
      m_err <= 1'b0;
      m_valid <= 1'b0;
      core_data <= '0;
      core_addr <= '0;
      core_sys_status <= SYS_IDLE;
      core_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_LOAD_TEMP;
          busy <= 1'b1;
          idx <= '0;
          s_ready <= 1'b1;
        end
        ST_LOAD_TEMP, ST_LOAD_TEST: begin
          core_en <= 1'b0;
          if (hs && len_err) begin
            state <= ST_RESULT;
            idx <= '0;
            s_ready <= 1'b0;
            m_data <= '0;
            m_err <= 1'b1;
            m_valid <= 1'b1;
            core_sys_status <= SYS_IDLE;
          end else if (hs) begin
            core_en <= 1'b1;
            core_data <= s_data;
            core_addr <= idx;
            core_sys_status <= state == ST_LOAD_TEMP ? SYS_LOAD_TEMP : SYS_LOAD_TEST;
            idx <= last_idx ? '0 : idx + 1'b1;
            if (last_idx) begin
              state <= state == ST_LOAD_TEMP ? ST_LOAD_TEST : ST_RUN;
              s_ready <= state == ST_LOAD_TEMP;
            end
          end
        end
        ST_RUN: begin
          core_sys_status <= SYS_RUN;
          core_en <= 1'b1;
          // done is checked first so it wins over a simultaneous watchdog expiry
          if (core_state == DONE_STATE || wd_expired) begin
            state <= ST_RESULT;
            m_data <= core_state == DONE_STATE ? core_result : '0;
            m_err <= core_state != DONE_STATE;
            m_valid <= 1'b1;
            core_en <= 1'b0;
            core_sys_status <= SYS_IDLE;
          end
        end
        ST_RESULT: if (m_ready) begin
          state <= ST_IDLE;
          m_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/dtw_host_sequencer.md
Name: dtw_host_sequencer

Overview:
- Host-side driver for the 4-feature/32-bit DTW core's load/run interface.
- Accepts a valid/ready sample stream: N_SAMPLES template words, then N_SAMPLES test words.
- Writes each word into the core by address, starts the computation and waits for the core's done state.
- Returns the captured DTW distance, with an error flag, on a valid/ready result port. Sits between the AXI register/stream front end and the DTW core.

Parameters:
- N_SAMPLES, 256: samples per sequence (template and test each).
- ADDR_W, 8: core sample address width.
- DATA_W, 32: sample and result width (4 features x 8 bit).
- DONE_STATE, 4'b1001: core state code meaning "result valid".
- TIMEOUT_W, 20: width of the run-phase watchdog counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a job
- busy  out  1  high from start acceptance until the result handshake completes
- s_data  in  DATA_W  sample word
- s_valid  in  1  sample valid
- s_ready  out  1  sample ready
- s_last  in  1  marks the final word of each sequence
- m_data  out  DATA_W  DTW result
- m_err  out  1  result is invalid (length error or timeout)
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- core_data  out  DATA_W  to core data_in
- core_addr  out  ADDR_W  to core data_addr
- core_sys_status  out  2  to core sys_status
- core_en  out  1  to core en
- core_state  in  4  from core dtw_state_out
- core_result  in  DATA_W  from core dtw_out

Behaviour:
- All outputs are registered.
- Reset values: every output 0; FSM = IDLE; sample index = 0; watchdog = 0.
- sys_status encoding, fixed in the package: IDLE=2'b00, LOAD_TEMP=2'b01, LOAD_TEST=2'b10, RUN=2'b11.
- FSM states: IDLE, LOAD_TEMP, LOAD_TEST, RUN, RESULT.
- IDLE:
  - start=1 -> LOAD_TEMP; busy<=1; idx<=0.
  - start while busy is ignored.
- LOAD_TEMP / LOAD_TEST:
  - s_ready=1. No other state asserts s_ready.
  - Each handshake (s_valid&s_ready) registers, effective next cycle: core_data<=s_data, core_addr<=idx, core_sys_status<=state code, core_en<=1 for exactly one cycle.
  - idx increments on each handshake.
  - No handshake in a cycle -> core_en<=0 next cycle.
  - Accept with idx==N_SAMPLES-1 and s_last=1 -> idx<=0 and advance: LOAD_TEMP->LOAD_TEST, LOAD_TEST->RUN.
  - s_last=1 with idx<N_SAMPLES-1, or s_last=0 with idx==N_SAMPLES-1 -> length error. Go to RESULT with m_err=1, m_data=0, core_en<=0, core_sys_status<=IDLE.
- RUN:
  - core_sys_status=RUN and core_en=1 held continuously; watchdog increments every cycle.
  - The first cycle with core_state==DONE_STATE -> m_data<=core_result, m_err<=0, m_valid<=1, core_en<=0, core_sys_status<=IDLE -> RESULT.
  - Watchdog reaching all-ones before done -> m_data<=0, m_err<=1, m_valid<=1, core released to IDLE -> RESULT.
  - If done and watchdog saturation occur in the same cycle, done wins.
- RESULT:
  - m_valid, m_data and m_err are held stable until m_ready.
  - On the handshake: m_valid<=0, busy<=0 -> IDLE.
  - start in the same cycle as the result handshake is ignored; a new start is honoured from the next cycle.
- Latency: load-phase sample-to-core_en is 1 cycle. Result appears 1 cycle after DONE_STATE is observed.
- Address wrap: idx never exceeds N_SAMPLES-1; ADDR_W must be >= clog2(N_SAMPLES), checked at elaboration.
- Reset mid-operation: immediate return to IDLE, core_en=0, m_valid=0, s_ready=0. No partial result is ever presented.

Decomposition:
- Package dtw_pkg holds:
  - sys_status codes: SYS_IDLE, SYS_LOAD_TEMP, SYS_LOAD_TEST, SYS_RUN.
  - DONE_STATE constant.
  - FSM state enum.
  - Default N_SAMPLES and DATA_W.
- Single optional sub-module dtw_watchdog: saturating counter with clear and enable, outputs an expired flag.

Test Plan:
- Nominal job: start; 256 template words 0x01010101..; 256 test words identical; core model asserts DONE_STATE after 1000 cycles with core_result=0 -> m_valid=1, m_data=0, m_err=0. Check core_addr runs 0..255 twice, with sys_status 01 then 10.
- Backpressure: s_valid toggled randomly, m_ready held low 50 cycles -> core_en pulses equal the handshake count (512); m_data stays stable until m_ready, then busy drops.
- Early s_last at template word 100 -> m_valid with m_err=1, m_data=0; core_sys_status returns to 00; no RUN phase occurs.
- Timeout: core never reports DONE_STATE, TIMEOUT_W=8 -> m_err=1 after 255 RUN cycles.
- Reset asserted mid-LOAD_TEST (word 37) -> all outputs 0 asynchronously; a fresh job after release completes correctly from address 0.
- start during busy and start coincident with the result handshake -> both ignored; the next start one cycle later begins LOAD_TEMP.
